aes_sbox_scheduler: RTL
=======================

# aes_sbox_scheduler

Time-shares one 32-bit S-box word unit (four byte substitutions) between the two consumers of SubBytes in the AES core: key expansion (one 32-bit SubWord per request) and the round datapath (a full 128-bit state per request, processed as four words). Each client has a valid/ready request port and a single-cycle response strobe. The block replaces per-client 128-bit S-box banks with one shared 4-byte unit and enforces fair, deterministic arbitration.

## Interface
Parameters: none (AES-128 widths fixed).
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- ke_req_valid  in  1  key-expansion request
- ke_req_word  in  32  word to substitute
- ke_req_ready  out  1  request accepted on this edge when high with valid
- ke_rsp_valid  out  1  one-cycle strobe, ke_rsp_word valid
- ke_rsp_word  out  32  substituted word
- rd_req_valid  in  1  round-datapath request
- rd_req_state  in  128  state to substitute
- rd_req_ready  out  1  request accepted on this edge when high with valid
- rd_rsp_valid  out  1  one-cycle strobe, rd_rsp_state valid
- rd_rsp_state  out  128  substituted state
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Byte k of any bus is bits [8k+7:8k]; each byte maps through the standard AES forward S-box (00→63, 01→7c, 53→ed, ff→16); bytes independent.
- FSM states: IDLE, KE, RD0, RD1, RD2, RD3.
- Accept slot: cycle in IDLE, KE or RD3. Only in an accept slot may a ready be high.
- Arbitration in accept slot: only one valid → grant it. Both valid → round-robin via last_grant flag: grant the client not granted last. last_grant resets to RD, so KE wins the first tie.
- ready = accept_slot & granted; never both readies high in one cycle. Ready may depend combinationally on the other client's valid.
- On KE accept: latch word into hold register; next state KE. On RD accept: latch state; next state RD0. No accept in slot: next state IDLE.
- KE cycle: S-box unit fed hold word; result registered into ke_rsp_word at end of cycle; ke_rsp_valid high the following cycle.
- RDn cycle (n=0..3): unit fed hold[32n+31:32n]; result written to rd_rsp_state[32n+31:32n] at end of cycle. rd_rsp_valid high the cycle after RD3.
- Response outputs hold their last value between strobes; no response backpressure (clients must consume on strobe).
- Request inputs sampled only on the accepting edge; changes afterwards ignored.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, last_grant RD, all outputs 0 (rsp_valids, rsp data, busy); readies follow accept-slot rule once rst_n high.
- KE latency: accept edge E0 → ke_rsp_valid high in cycle after E1 (2 cycles).
- RD latency: accept edge E0 → rd_rsp_valid high in cycle after E4 (5 cycles).
- Throughput: back-to-back KE one word/cycle; back-to-back RD one state per 4 cycles; accept in KE/RD3 gives zero idle cycles.
- A response strobe may coincide with a new accept or with the other client's strobe? No: strobes are mutually exclusive by construction.
- rst_n asserted mid-operation: in-flight request discarded, no response strobe issued.

## Structure
- Package aes_pkg: byte/word/state typedefs, FSM state enum, client-id enum, S-box lookup function (shared with existing SubBytes).
- Sub-module aes_sbox_word: combinational 32-bit → 32-bit, four S-box lookups; single instance here.

## Test plan
- KE only: ke_req_word=0x00010253 → ke_rsp_valid exactly 2 cycles after accept, ke_rsp_word=0x637c77ed.
- RD only: rd_req_state=0x000102030405060708090a0b0c0d0e0f → rd_rsp_valid 5 cycles after accept, rd_rsp_state=0x637c777bf26b6fc53001672bfed7ab76; busy high 4 cycles.
- Both valid continuously from reset: grants alternate KE, RD, KE, RD; no ready asserted outside accept slots; readies never both high.
- Back-to-back KE words 0x00000000, 0xffffffff → consecutive strobes 0x63636363, 0x16161616, no gap.
- rst_n low during RD2 → all outputs 0 immediately, no rd_rsp_valid; after release a KE request completes normally with KE winning first tie.
- Request inputs changed after accept edge → response reflects latched value only.

Source files
------------

// File: rtl/aes_sbox_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the SubBytes consumers. It provides:
//   - byte/word/state typedefs
//   - scheduler FSM state encodings
//   - client identifiers
//   - the forward S-box table and its lookup function
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] aes_state_t;

  // Scheduler FSM encodings, kept as plain constants for legacy tooling.
  typedef logic [2:0] fsm_t;
  localparam fsm_t ST_IDLE = 3'd0;
  localparam fsm_t ST_KE   = 3'd1;
  localparam fsm_t ST_RD0  = 3'd2;
  localparam fsm_t ST_RD1  = 3'd3;
  localparam fsm_t ST_RD2  = 3'd4;
  localparam fsm_t ST_RD3  = 3'd5;

  typedef enum logic {
    CLIENT_KE = 1'b0,
    CLIENT_RD = 1'b1
  } client_e;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic byte_t sbox_lookup(input byte_t b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_scheduler_if.sv
// -----------------------------------------------------------------------------
// aes_sbox_scheduler_if
// Request/response bundle between the two SubBytes clients and the scheduler.
//   ke_req_*  / ke_rsp_*  : key-expansion word port
//   rd_req_*  / rd_rsp_*  : round-datapath state port
// Modports:
//   master : client side (drives requests, receives readies/responses)
//   slave  : scheduler side
// -----------------------------------------------------------------------------
interface aes_sbox_scheduler_if;
  import aes_pkg::*;

  logic       ke_req_valid;
  word_t      ke_req_word;
  logic       ke_req_ready;
  logic       ke_rsp_valid;
  word_t      ke_rsp_word;

  logic       rd_req_valid;
  aes_state_t rd_req_state;
  logic       rd_req_ready;
  logic       rd_rsp_valid;
  aes_state_t rd_rsp_state;

  modport master (
    output ke_req_valid, ke_req_word,
    input  ke_req_ready, ke_rsp_valid, ke_rsp_word,
    output rd_req_valid, rd_req_state,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_state
  );

  modport slave (
    input  ke_req_valid, ke_req_word,
    output ke_req_ready, ke_rsp_valid, ke_rsp_word,
    input  rd_req_valid, rd_req_state,
    output rd_req_ready, rd_rsp_valid, rd_rsp_state
  );

endinterface

// File: rtl/aes_sbox_scheduler_sbox_word.sv
// -----------------------------------------------------------------------------
// aes_sbox_word
// Combinational 32-bit SubWord: four independent forward S-box lookups.
//   word_i : input word, byte k = bits [8k+7:8k]
//   word_o : substituted word
// -----------------------------------------------------------------------------
module aes_sbox_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign word_o[8*k +: 8] = sbox_lookup(word_i[8*k +: 8]);
  end

endmodule

// File: rtl/aes_sbox_scheduler.sv
// -----------------------------------------------------------------------------
// aes_sbox_scheduler
// Time-shares one 32-bit S-box word unit between key expansion (one word per
// request, 2-cycle latency) and the round datapath (128-bit state per request,
// four words, 5-cycle latency). Ties are broken round-robin.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : client request/response bundle (slave side)
//   busy  : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module aes_sbox_scheduler
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_sbox_scheduler_if.slave  bus,
  output logic                 busy
);

  fsm_t       state_q, state_d;
  client_e    last_grant_q, last_grant_d;
  aes_state_t hold_q, hold_d;

  logic       ke_rsp_valid_q;
  word_t      ke_rsp_word_q;
  logic       rd_rsp_valid_q;
  aes_state_t rd_rsp_state_q;

  logic       accept_slot;
  logic       rd_active;
  logic       grant_ke;
  logic       grant_rd;
  logic [1:0] word_sel;
  word_t      unit_in;
  word_t      unit_out;

  // IDLE, KE and RD3 are the only cycles where the unit is free next cycle.
  assign accept_slot = (state_q == ST_IDLE) || (state_q == ST_KE) || (state_q == ST_RD3);
  assign rd_active   = (state_q == ST_RD0) || (state_q == ST_RD1) ||
                       (state_q == ST_RD2) || (state_q == ST_RD3);

  // On a tie the client not served last wins; a lone requester always wins.
  assign grant_ke = accept_slot && bus.ke_req_valid &&
                    (!bus.rd_req_valid || (last_grant_q == CLIENT_RD));
  assign grant_rd = accept_slot && bus.rd_req_valid &&
                    (!bus.ke_req_valid || (last_grant_q == CLIENT_KE));

  assign bus.ke_req_ready = grant_ke;
  assign bus.rd_req_ready = grant_rd;
  assign bus.ke_rsp_valid = ke_rsp_valid_q;
  assign bus.ke_rsp_word  = ke_rsp_word_q;
  assign bus.rd_rsp_valid = rd_rsp_valid_q;
  assign bus.rd_rsp_state = rd_rsp_state_q;
  assign busy             = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    state_d      = ST_IDLE;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;

    case (state_q)
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_RD3;
      default: state_d = ST_IDLE;
    endcase

    if (grant_ke) begin
      state_d        = ST_KE;
      last_grant_d   = CLIENT_KE;
      hold_d[31:0]   = bus.ke_req_word;
    end else if (grant_rd) begin
      state_d        = ST_RD0;
      last_grant_d   = CLIENT_RD;
      hold_d         = bus.rd_req_state;
    end
  end

  // KE uses the low hold word; RDn uses word n.
  always_comb begin
    word_sel = 2'd0;
    case (state_q)
      ST_RD1:  word_sel = 2'd1;
      ST_RD2:  word_sel = 2'd2;
      ST_RD3:  word_sel = 2'd3;
      default: word_sel = 2'd0;
    endcase
  end

  assign unit_in = hold_q[{word_sel, 5'd0} +: 32];

  aes_sbox_word u_sbox_word (
    .word_i (unit_in),
    .word_o (unit_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CLIENT_RD;
      // NOTE: the wide hold register is reset too; it is ordinary flops, and a
      // known value keeps the datapath free of X after reset.
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
    end
  end

  // Responses: data holds between strobes; strobes follow KE and RD3 cycles,
  // which are never simultaneous, so the two strobes are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ke_rsp_valid_q <= 1'b0;
      ke_rsp_word_q  <= '0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_state_q <= '0;
    end else begin
      ke_rsp_valid_q <= (state_q == ST_KE);
      rd_rsp_valid_q <= (state_q == ST_RD3);
      if (state_q == ST_KE) begin
        ke_rsp_word_q <= unit_out;
      end
      if (rd_active) begin
        rd_rsp_state_q[{word_sel, 5'd0} +: 32] <= unit_out;
      end
    end
  end

endmodule
